// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer and sole writer of the CSR commit port.
// Trap entry runs MEPC -> MSTATUS -> MCAUSE -> JUMP and MRET runs MSTATUS -> JUMP.
// The pipeline is held from acceptance until the cycle after JUMP.
// Optional feature macro: TRAP_VECTORED_EN. When it is defined, async interrupts
// use vectored mtvec dispatch if mtvec[1:0] == 2'b01.
//
// Handshake: int_type_i and mret_i are level requests that are sampled only in IDLE.
// A source keeps its request asserted until int_ack_o pulses (trap) or jump_o pulses (MRET).
// Requests seen outside IDLE are ignored. ex_busy_i stops the first CSR write until ex has drained.
module trap_ctrl #(
  parameter int          NUM          = 5,
  parameter logic [31:0] CAUSE_ECALL  = 32'h0000000B,
  parameter logic [31:0] CAUSE_EBREAK = 32'h00000003,
  parameter logic [31:0] CAUSE_SWI    = 32'h80000003,
  parameter logic [31:0] CAUSE_TIMER  = 32'h80000007,
  parameter logic [31:0] CAUSE_PLIC   = 32'h8000000B,
  parameter logic [31:0] CAUSE_DEBUG  = 32'h80000010
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NUM-1:0] int_type_i,
  input  logic [31:0]    inst_addr_i,
  input  logic           mret_i,
  input  logic           ex_busy_i,
  input  logic           global_int_en_i,
  input  logic [31:0]    csr_mtvec_i,
  input  logic [31:0]    csr_mepc_i,
  input  logic [31:0]    csr_mstatus_i,
  output logic [NUM-1:0] int_type_o,
  output logic           csr_wen_o,
  output logic [31:0]    csr_waddr_o,
  output logic [31:0]    csr_wdata_o,
  output logic           hold_o,
  output logic           jump_o,
  output logic [31:0]    jump_addr_o,
  output logic           int_ack_o
);

  // Trap type encodings. Bit 0 separates async interrupts (1) from sync exceptions (0).
  localparam logic [NUM-1:0] INT_ECALL  = NUM'(5'b00010);
  localparam logic [NUM-1:0] INT_EBREAK = NUM'(5'b00100);
  localparam logic [NUM-1:0] INT_SWI    = NUM'(5'b00011);
  localparam logic [NUM-1:0] INT_TIMER  = NUM'(5'b00101);
  localparam logic [NUM-1:0] INT_PLIC   = NUM'(5'b01001);
  localparam logic [NUM-1:0] INT_DEBUG  = NUM'(5'b10001);

  localparam logic [31:0] ADDR_MSTATUS = 32'h00000300;
  localparam logic [31:0] ADDR_MEPC    = 32'h00000341;
  localparam logic [31:0] ADDR_MCAUSE  = 32'h00000342;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_W_MEPC   = 3'd2,
    S_W_MSTAT  = 3'd3,
    S_W_MCAUSE = 3'd4,
    S_R_MSTAT  = 3'd5,
    S_JUMP     = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [NUM-1:0] type_q, type_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    cause_q, cause_d;
  logic           mret_q, mret_d;

  logic           dec_valid;
  logic [31:0]    dec_cause;
  logic           req_sync;
  logic           req_async;
  logic           take_trap;
  logic           take_mret;
  logic           accept;
  logic [31:0]    trap_target;

  // Decode the requested trap type into its mcause value. Unknown codes are not valid.
  always_comb begin
    dec_valid = 1'b1;
    dec_cause = '0;
    case (int_type_i)
      INT_ECALL:  dec_cause = CAUSE_ECALL;
      INT_EBREAK: dec_cause = CAUSE_EBREAK;
      INT_SWI:    dec_cause = CAUSE_SWI;
      INT_TIMER:  dec_cause = CAUSE_TIMER;
      INT_PLIC:   dec_cause = CAUSE_PLIC;
      INT_DEBUG:  dec_cause = CAUSE_DEBUG;
      default:    dec_valid = 1'b0;
    endcase
  end

  // Acceptance priority: sync exception, then MRET, then an enabled async interrupt.
  // Acceptance is blocked while rst is high so that every output stays 0 in IDLE during reset.
  always_comb begin
    req_sync  = dec_valid & ~int_type_i[0];
    req_async = dec_valid & int_type_i[0] & global_int_en_i;
    take_trap = ~rst & (state_q == S_IDLE) & (req_sync | (req_async & ~mret_i));
    take_mret = ~rst & (state_q == S_IDLE) & ~req_sync & mret_i;
    accept    = take_trap | take_mret;
  end

  // Redirect target for trap entry. With the vectored option, async interrupts are offset by cause.
  always_comb begin
    trap_target = csr_mtvec_i;
`ifdef TRAP_VECTORED_EN
    if (type_q[0] && (csr_mtvec_i[1:0] == 2'b01)) begin
      trap_target = {csr_mtvec_i[31:2], 2'b00} + {25'd0, cause_q[4:0], 2'b00};
    end
`endif
  end

  // Next-state logic and latch updates for the sequencer.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    mret_d  = mret_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          type_d  = take_trap ? int_type_i : '0;
          pc_d    = inst_addr_i;
          cause_d = take_trap ? dec_cause : '0;
          mret_d  = take_mret;
          if (ex_busy_i) begin
            state_d = S_WAIT;
          end else if (take_mret) begin
            state_d = S_R_MSTAT;
          end else begin
            state_d = S_W_MEPC;
          end
        end
      end
      S_WAIT: begin
        if (!ex_busy_i) begin
          state_d = mret_q ? S_R_MSTAT : S_W_MEPC;
        end
      end
      S_W_MEPC:   state_d = S_W_MSTAT;
      S_W_MSTAT:  state_d = S_W_MCAUSE;
      S_W_MCAUSE: state_d = S_JUMP;
      S_R_MSTAT:  state_d = S_JUMP;
      S_JUMP: begin
        state_d = S_IDLE;
        type_d  = '0;
        pc_d    = '0;
        cause_d = '0;
        mret_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        type_d  = '0;
        pc_d    = '0;
        cause_d = '0;
        mret_d  = 1'b0;
      end
    endcase
  end

  // Moore outputs: one CSR write per write state, and the redirect in JUMP.
  // Hold and int_type_o also cover the acceptance cycle.
  always_comb begin
    csr_wen_o   = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    int_ack_o   = 1'b0;
    hold_o      = (state_q != S_IDLE) | accept;
    int_type_o  = (state_q == S_IDLE) ? (take_trap ? int_type_i : '0) : type_q;
    case (state_q)
      S_W_MEPC: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = pc_q;
      end
      S_W_MSTAT: begin
        // Save MIE into MPIE, then clear MIE.
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                       1'b0, csr_mstatus_i[2:0]};
      end
      S_W_MCAUSE: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      S_R_MSTAT: begin
        // Restore MIE from MPIE, then set MPIE.
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                       csr_mstatus_i[7], csr_mstatus_i[2:0]};
      end
      S_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = mret_q ? csr_mepc_i : trap_target;
        int_ack_o   = ~mret_q;
      end
      default: begin
      end
    endcase
  end

  // State and latch registers. A synchronous reset drops any sequence in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scenarios followed by randomized cycles. A transaction-level
// reference model (a queue of pending CSR steps for each accepted request) predicts
// every output in every cycle.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  int_type_i;
  logic [31:0] inst_addr_i;
  logic        mret_i;
  logic        ex_busy_i;
  logic        global_int_en_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic [4:0]  int_type_o;
  logic        csr_wen_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        hold_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;
  logic        int_ack_o;

  // clock / reset
  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .int_type_i      (int_type_i),
    .inst_addr_i     (inst_addr_i),
    .mret_i          (mret_i),
    .ex_busy_i       (ex_busy_i),
    .global_int_en_i (global_int_en_i),
    .csr_mtvec_i     (csr_mtvec_i),
    .csr_mepc_i      (csr_mepc_i),
    .csr_mstatus_i   (csr_mstatus_i),
    .int_type_o      (int_type_o),
    .csr_wen_o       (csr_wen_o),
    .csr_waddr_o     (csr_waddr_o),
    .csr_wdata_o     (csr_wdata_o),
    .hold_o          (hold_o),
    .jump_o          (jump_o),
    .jump_addr_o     (jump_addr_o),
    .int_ack_o       (int_ack_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model
  typedef enum {K_MEPC, K_MSTAT, K_MCAUSE, K_RMSTAT, K_JUMP} kind_e;
  kind_e       steps_q[$];
  bit          m_active = 0;
  bit          m_wait   = 0;
  bit          m_mret   = 0;
  logic [4:0]  m_type   = '0;
  logic [31:0] m_pc     = '0;
  logic [31:0] m_cause  = '0;

  // Log of CSR writes and redirects, used by the directed scenarios.
  logic [31:0] exp_q[$];
  logic [31:0] wr_addr_l[8];
  logic [31:0] wr_data_l[8];
  logic [31:0] jmp_l[8];
  int          n_wr, n_jmp, n_ack;

  function automatic bit code_known(input logic [4:0] t);
    return (t == 5'd2) || (t == 5'd4) || (t == 5'd3) || (t == 5'd5) || (t == 5'd9) || (t == 5'd17);
  endfunction

  function automatic logic [31:0] cause_of(input logic [4:0] t);
    case (t)
      5'd2:    return 32'h0000000B;
      5'd4:    return 32'h00000003;
      5'd3:    return 32'h80000003;
      5'd5:    return 32'h80000007;
      5'd9:    return 32'h8000000B;
      5'd17:   return 32'h80000010;
      default: return 32'h0;
    endcase
  endfunction

  task automatic clr_log();
    n_wr = 0;
    n_jmp = 0;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      wr_addr_l[i] = 32'hDEADBEEF;
      wr_data_l[i] = 32'hDEADBEEF;
      jmp_l[i]     = 32'hDEADBEEF;
    end
  endtask

  task automatic idle_inputs();
    int_type_i = '0;
    mret_i     = 1'b0;
    ex_busy_i  = 1'b0;
  endtask

  // Check one cycle against the model, log activity, then advance to just after the next edge.
  task automatic tick();
    logic        e_hold, e_wen, e_jump, e_ack;
    logic [31:0] e_addr, e_data, e_jaddr;
    logic [4:0]  e_type;
    bit          sync_r, async_r;
    kind_e       k;
    #2;
    e_hold = 0; e_wen = 0; e_jump = 0; e_ack = 0;
    e_addr = '0; e_data = '0; e_jaddr = '0; e_type = '0;
    if (!m_active) begin
      sync_r  = code_known(int_type_i) && !int_type_i[0];
      async_r = code_known(int_type_i) && int_type_i[0] && global_int_en_i;
      if (!rst && (sync_r || mret_i || async_r)) begin
        m_active = 1;
        m_mret   = !sync_r && mret_i;
        m_type   = m_mret ? 5'd0 : int_type_i;
        m_pc     = inst_addr_i;
        m_cause  = cause_of(int_type_i);
        m_wait   = ex_busy_i;
        if (m_mret) steps_q = '{K_RMSTAT, K_JUMP};
        else        steps_q = '{K_MEPC, K_MSTAT, K_MCAUSE, K_JUMP};
        e_hold = 1;
        e_type = m_type;
      end
    end else if (m_wait) begin
      e_hold = 1;
      e_type = m_type;
      if (!ex_busy_i) m_wait = 0;
    end else begin
      k = steps_q.pop_front();
      e_hold = 1;
      e_type = m_type;
      case (k)
        K_MEPC:   begin e_wen = 1; e_addr = 32'h341; e_data = m_pc; end
        K_MSTAT:  begin
          e_wen = 1; e_addr = 32'h300;
          e_data = (csr_mstatus_i & ~32'h88) | (csr_mstatus_i[3] ? 32'h80 : 32'h0);
        end
        K_MCAUSE: begin e_wen = 1; e_addr = 32'h342; e_data = m_cause; end
        K_RMSTAT: begin
          e_wen = 1; e_addr = 32'h300;
          e_data = (csr_mstatus_i & ~32'h88) | (csr_mstatus_i[7] ? 32'h8 : 32'h0) | 32'h80;
        end
        default: begin
          e_jump = 1;
          e_ack  = !m_mret;
          if (m_mret) e_jaddr = csr_mepc_i;
          else        e_jaddr = csr_mtvec_i;
`ifdef TRAP_VECTORED_EN
          if (!m_mret && m_type[0] && (csr_mtvec_i[1:0] == 2'b01))
            e_jaddr = (csr_mtvec_i & ~32'h3) + ((m_cause & 32'h1F) * 4);
`endif
        end
      endcase
      if (steps_q.size() == 0) m_active = 0;
    end
    check("hold",      32'(hold_o),      32'(e_hold));
    check("csr_wen",   32'(csr_wen_o),   32'(e_wen));
    check("csr_waddr", csr_waddr_o,      e_addr);
    check("csr_wdata", csr_wdata_o,      e_data);
    check("jump",      32'(jump_o),      32'(e_jump));
    check("jump_addr", jump_addr_o,      e_jaddr);
    check("int_ack",   32'(int_ack_o),   32'(e_ack));
    check("int_type",  32'(int_type_o),  32'(e_type));
    if (rst) begin
      m_active = 0;
      m_wait   = 0;
      steps_q.delete();
    end
    if (csr_wen_o && n_wr < 8) begin
      wr_addr_l[n_wr] = csr_waddr_o;
      wr_data_l[n_wr] = csr_wdata_o;
      n_wr++;
    end
    if (jump_o && n_jmp < 8) begin
      jmp_l[n_jmp] = jump_addr_o;
      n_jmp++;
    end
    if (int_ack_o) n_ack++;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] codes[13];

  initial begin
    codes = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd4, 5'd3, 5'd5, 5'd9, 5'd17, 5'd1, 5'd6, 5'd31};
    rst = 1'b1;
    idle_inputs();
    global_int_en_i = 1'b0;
    inst_addr_i     = '0;
    csr_mtvec_i     = '0;
    csr_mepc_i      = '0;
    csr_mstatus_i   = '0;
    clr_log();
    @(posedge clk);
    #1;
    tick();                     // reset state: every output 0
    rst = 1'b0;
    tick();

    // ECALL entry
    csr_mtvec_i = 32'h2C4; csr_mstatus_i = 32'h88; inst_addr_i = 32'h100;
    int_type_i = 5'b00010;
    clr_log();
    tick();
    int_type_i = '0;
    repeat (5) tick();
    exp_q = '{32'h341, 32'h100, 32'h300, 32'h80, 32'h342, 32'hB};
    check("t1_nwr", n_wr, 3);
    for (int i = 0; i < 3; i++) begin
      check("t1_waddr", wr_addr_l[i], exp_q.pop_front());
      check("t1_wdata", wr_data_l[i], exp_q.pop_front());
    end
    check("t1_jump", jmp_l[0], 32'h2C4);
    check("t1_ack",  n_ack, 1);

    // MRET
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    mret_i = 1'b1;
    clr_log();
    tick();
    mret_i = 1'b0;
    repeat (3) tick();
    check("t2_nwr",   n_wr, 1);
    check("t2_waddr", wr_addr_l[0], 32'h300);
    check("t2_wdata", wr_data_l[0], 32'h88);
    check("t2_jump",  jmp_l[0], 32'h104);
    check("t2_ack",   n_ack, 0);

    // masked TIMER, then enabled
    global_int_en_i = 1'b0;
    int_type_i = 5'b00101;
    clr_log();
    repeat (3) tick();
    check("t3_masked_nwr", n_wr, 0);
    global_int_en_i = 1'b1;
    tick();
    int_type_i = '0;
    repeat (5) tick();
    check("t3_mcause", wr_data_l[2], 32'h80000007);

    // TIMER with ex busy for 3 cycles
    int_type_i = 5'b00101; ex_busy_i = 1'b1;
    clr_log();
    tick();
    int_type_i = '0;
    repeat (2) tick();
    ex_busy_i = 1'b0;
    repeat (6) tick();
    check("t4_nwr", n_wr, 3);

    // ECALL and MRET together
    int_type_i = 5'b00010; mret_i = 1'b1;
    clr_log();
    tick();
    idle_inputs();
    repeat (5) tick();
    check("t5_mcause", wr_data_l[2], 32'hB);
    check("t5_njmp",   n_jmp, 1);

    // reset during W_MSTAT
    int_type_i = 5'b00100;
    clr_log();
    tick();
    int_type_i = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t5_rst_nwr", n_wr, 2);
    check("t5_rst_ack", n_ack, 0);

    // PLIC with mtvec mode bits 01
    csr_mtvec_i = 32'h201; global_int_en_i = 1'b1;
    int_type_i = 5'b01001;
    clr_log();
    tick();
    int_type_i = '0;
    repeat (5) tick();
`ifdef TRAP_VECTORED_EN
    check("t6_jump", jmp_l[0], 32'h22C);
`else
    check("t6_jump", jmp_l[0], 32'h201);
`endif

    // randomized cycles
    for (int c = 0; c < 800; c++) begin
      int_type_i      = codes[$urandom_range(0, 12)];
      mret_i          = ($urandom_range(0, 5) == 0);
      ex_busy_i       = ($urandom_range(0, 2) == 0);
      global_int_en_i = 1'($urandom_range(0, 1));
      inst_addr_i     = $urandom();
      csr_mtvec_i     = $urandom();
      csr_mepc_i      = $urandom();
      csr_mstatus_i   = $urandom();
      rst             = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
